mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 64-bit multiply/divide execute unit for the ARM (LEGv8) datapath. It consumes the two operands read from the register file (read_data1/read_data2) plus the destination register number. It produces a result with a one-cycle write-enable pulse that drives the register file's reg_write/write_register/write_data inputs through the write-back mux. It implements MUL, UDIV and SDIV in a multi-cycle FSM, so the single-cycle ALU path stays short.

## Interface
Parameters:
- dataWidth, 64, operand/result width (must equal the register file data width)
- addressWidth, 5, destination register number width
- cntWidth, 6, iteration counter width (log2 dataWidth)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- start  in  1  request; sampled only when busy=0
- op  in  2  00 MUL (low 64 bits), 01 UDIV, 10 SDIV, 11 reserved
- operand_a  in  dataWidth  Rn value (multiplicand / dividend)
- operand_b  in  dataWidth  Rm value (multiplier / divisor)
- dest_register  in  addressWidth  Rd number, captured with start
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse; result valid in the same cycle
- reg_write  out  1  identical to done (register file write enable)
- result  out  dataWidth  product low half or quotient; holds its value until the next done
- result_register  out  addressWidth  captured dest_register, valid with done

## Operation
- States: IDLE, CALC, FINISH. Encoding lives in the package.
- IDLE with start=1: capture op, operands and dest_register.
  - op=01/10 with operand_b=0 goes to FINISH; result is 0 (ARM divide-by-zero semantics).
  - op=11 goes to FINISH; result is 0.
  - All other cases go to CALC with counter=0.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Accumulate modulo 2^64; sign-agnostic.
- UDIV: restoring division, one quotient bit per cycle, MSB first. There is one shared 64-bit subtractor; the remainder is discarded.
- SDIV: divide the operand magnitudes unsigned. Negate the quotient if the operand signs differ, so the result truncates toward zero.
  - 0x8000_0000_0000_0000 / -1 yields 0x8000_0000_0000_0000 (wraps; no trap).
- CALC runs exactly 64 cycles (counter 0..63). After counter=63 the FSM goes to FINISH, and the SDIV sign fix is applied on that transition.
- FINISH lasts one cycle: done=reg_write=1, result and result_register valid. The next state is IDLE.
- start while busy=1 (CALC or FINISH) is ignored and not queued. The upstream stage must hold until busy=0.
- Operand inputs may change after the start cycle; only the captured copies are used.

## Timing
- Reset values: busy=0, done=0, reg_write=0, result=0, result_register=0, state=IDLE, counter=0.
- Normal latency: start sampled at edge N; busy=1 from edge N; done=1 for the single cycle following edge N+65; busy=0 and IDLE from edge N+66.
  - Earliest next start is sampled at edge N+66.
- Fast path (divide by zero, op=11): done in the cycle after edge N+1; IDLE from edge N+2.
- Reset asserted mid-CALC or mid-FINISH: the operation is abandoned and all outputs return to reset values asynchronously. No done or reg_write is issued for the abandoned operation.
- done is never high for two consecutive cycles.

## Structure
- Shared package (shared with the ALU/control decode): op encodings (OP_MUL, OP_UDIV, OP_SDIV, OP_RSVD), FSM state encodings, DATA_WIDTH=64, REG_ADDR_WIDTH=5.
- Single module; no sub-module required. The datapath is one 64-bit adder/subtractor, a 128-bit shift pair (accumulator/remainder plus operand), and a 6-bit counter.
- Expected size: about 150-250 lines of RTL.

## Test plan
- MUL 7 x 6, dest=3: start at edge N -> done/reg_write single pulse after edge N+65; result=42; result_register=3; busy low at N+66.
- UDIV 100/7 -> result 14. SDIV -100/7 -> 0xFFFF_FFFF_FFFF_FFF2. SDIV -100/-7 -> 14. All with 65-cycle latency.
- SDIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> result 0x8000_0000_0000_0000. MUL 0xFFFF_FFFF_FFFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE.
- UDIV 5/0 and op=11 -> result 0, done after edge N+1, busy low after edge N+2.
- Second start pulses at N+10 and during FINISH -> ignored: exactly one done, and the result comes from the first operands.
- reset at N+30 mid-MUL -> all outputs 0 immediately, no done pulse. A new MUL 3 x 5 started after reset release -> 15 after 65 cycles.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide execute unit and the ALU/control decode.
package mul_div_unit_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CNT_WIDTH      = 6;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_UDIV = 2'b01,
        OP_SDIV = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int dataWidth    = DATA_WIDTH,
    parameter int addressWidth = REG_ADDR_WIDTH
) ();
    logic                    start;
    logic [1:0]              op;
    logic [dataWidth-1:0]    operand_a;
    logic [dataWidth-1:0]    operand_b;
    logic [addressWidth-1:0] dest_register;
    logic                    busy;
    logic                    done;
    logic                    reg_write;
    logic [dataWidth-1:0]    result;
    logic [addressWidth-1:0] result_register;

    modport master (
        output start, op, operand_a, operand_b, dest_register,
        input  busy, done, reg_write, result, result_register
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_register,
        output busy, done, reg_write, result, result_register
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 64-bit MUL / UDIV / SDIV unit. One operand bit per cycle through a
// single shared adder/subtractor over a {hi_q, lo_q} shift pair.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting; issue_q marks the decode cycle right after a capture
// ST_CALC   | 64 iterations, counter 0..63
// ST_FINISH | done/reg_write high, result valid for one cycle
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int dataWidth    = DATA_WIDTH,
    parameter int addressWidth = REG_ADDR_WIDTH,
    parameter int cntWidth     = CNT_WIDTH
) (
    input logic          clock,
    input logic          reset,
    mul_div_unit_if.slave bus
);

    state_e                  state_q;
    op_e                     op_q;
    logic                    issue_q;
    logic                    fast_q;
    logic                    neg_q;
    logic                    busy_q;
    logic                    done_q;
    logic [cntWidth-1:0]     cnt_q;
    logic [dataWidth-1:0]    hi_q;
    logic [dataWidth-1:0]    lo_q;
    logic [dataWidth-1:0]    m_q;
    logic [dataWidth-1:0]    result_q;
    logic [addressWidth-1:0] rd_q;

    logic                    is_div;
    logic [dataWidth:0]      shifted;
    logic [dataWidth:0]      add_x;
    logic [dataWidth:0]      add_y;
    logic [dataWidth+1:0]    sum;
    logic [dataWidth-1:0]    hi_d;
    logic [dataWidth-1:0]    lo_d;
    logic                    div_zero;

    // Divides shift {rem, dividend} left and trial-subtract; multiply adds the
    // multiplicand when the multiplier LSB is set and shifts {acc, mplier} right,
    // so the low product half ends up in lo_q.
    always_comb begin
        is_div  = (op_q != OP_MUL);
        shifted = {hi_q, lo_q[dataWidth-1]};
        add_x   = is_div ? shifted : {1'b0, hi_q};
        add_y   = is_div ? ~{1'b0, m_q} : (lo_q[0] ? {1'b0, m_q} : '0);
        sum     = {1'b0, add_x} + {1'b0, add_y} + {{(dataWidth+1){1'b0}}, is_div};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (is_div) begin
            if (sum[dataWidth+1]) begin
                hi_d = sum[dataWidth-1:0];
                lo_d = {lo_q[dataWidth-2:0], 1'b1};
            end else begin
                hi_d = shifted[dataWidth-1:0];
                lo_d = {lo_q[dataWidth-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[dataWidth:1];
            lo_d = {sum[0], lo_q[dataWidth-1:1]};
        end
    end

    // Divide-by-zero only matters for the two divide opcodes.
    always_comb begin
        div_zero = (bus.operand_b == '0) &&
                   ((op_e'(bus.op) == OP_UDIV) || (op_e'(bus.op) == OP_SDIV));
    end

    // Control FSM with registered outputs and operand capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            issue_q  <= 1'b0;
            fast_q   <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_q) begin
                        issue_q <= 1'b0;
                        cnt_q   <= '0;
                        if (fast_q) begin
                            state_q  <= ST_FINISH;
                            done_q   <= 1'b1;
                            result_q <= '0;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end else if (bus.start) begin
                        issue_q <= 1'b1;
                        busy_q  <= 1'b1;
                        op_q    <= op_e'(bus.op);
                        rd_q    <= bus.dest_register;
                        fast_q  <= div_zero || (op_e'(bus.op) == OP_RSVD);
                        hi_q    <= '0;
                        neg_q   <= 1'b0;
                        case (op_e'(bus.op))
                            OP_SDIV: begin
                                lo_q  <= magnitude(bus.operand_a);
                                m_q   <= magnitude(bus.operand_b);
                                neg_q <= bus.operand_a[dataWidth-1] ^ bus.operand_b[dataWidth-1];
                            end
                            OP_UDIV: begin
                                lo_q <= bus.operand_a;
                                m_q  <= bus.operand_b;
                            end
                            default: begin
                                lo_q <= bus.operand_b;
                                m_q  <= bus.operand_a;
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + {{(cntWidth-1){1'b0}}, 1'b1};
                    if (cnt_q == {cntWidth{1'b1}}) begin
                        state_q  <= ST_FINISH;
                        done_q   <= 1'b1;
                        result_q <= neg_q ? (~lo_d + 1'b1) : lo_d;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.reg_write       = done_q;
    assign bus.result          = result_q;
    assign bus.result_register = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases with literal results plus random ops,
// all checked every cycle against an arithmetic reference model.
module tb_mul_div_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          exp_start = 1;
    int          exp_done = 0;
    logic [63:0] exp_res = '0;
    logic [4:0]  exp_rd = '0;
    logic [63:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
        case (o)
            2'd0: return a * b;
            2'd1: return (b == 0) ? 64'd0 : a / b;
            2'd2: begin
                if (b == 0) return 64'd0;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
                return 64'(sa / sb);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Cycle-by-cycle comparison against the model, sampled 2 ns after each edge.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            cyc++;
            chk("busy", 64'(bus.busy), 64'((cyc >= exp_start) && (cyc <= exp_done)));
            chk("done", 64'(bus.done), 64'(cyc == exp_done));
            chk("reg_write", 64'(bus.reg_write), 64'(cyc == exp_done));
            if (cyc == exp_done) begin
                chk("result", bus.result, exp_res);
                chk("result_register", 64'(bus.result_register), 64'(exp_rd));
                held = exp_res;
            end else begin
                chk("result_hold", bus.result, held);
            end
        end
    end

    task automatic rand_inputs();
        bus.op            = 2'($urandom);
        bus.operand_a     = {$urandom, $urandom};
        bus.operand_b     = {$urandom, $urandom};
        bus.dest_register = 5'($urandom);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input bit use_lit, input logic [63:0] lit,
                          input bit poke);
        logic [63:0] e;
        bit          fast;
        @(negedge clock);
        e = model(o, a, b);
        if (use_lit) chk("model_pin", e, lit);
        fast = (o == 2'd3) || ((o == 2'd1 || o == 2'd2) && b == 0);
        bus.start         = 1'b1;
        bus.op            = o;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.dest_register = rd;
        exp_start         = cyc + 1;
        exp_done          = exp_start + (fast ? 1 : 65);
        exp_res           = e;
        exp_rd            = rd;
        @(negedge clock);
        bus.start = 1'b0;
        rand_inputs();
        while (cyc < exp_done) begin
            @(negedge clock);
            rand_inputs();
            bus.start = poke && (cyc == exp_start + 9 || cyc == exp_done);
        end
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start         = 1'b0;
        bus.op            = 2'd0;
        bus.operand_a     = '0;
        bus.operand_b     = '0;
        bus.dest_register = '0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_rd", 64'(bus.result_register), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        run_op(2'd0, 64'd7, 64'd6, 5'd3, 1, 64'd42, 0);
        run_op(2'd1, 64'd100, 64'd7, 5'd4, 1, 64'd14, 0);
        run_op(2'd2, -64'sd100, 64'd7, 5'd5, 1, 64'hFFFF_FFFF_FFFF_FFF2, 0);
        run_op(2'd2, -64'sd100, -64'sd7, 5'd6, 1, 64'd14, 0);
        run_op(2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1,
               64'h8000_0000_0000_0000, 0);
        run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op(2'd1, 64'd5, 64'd0, 5'd9, 1, 64'd0, 0);
        run_op(2'd3, 64'd123, 64'd45, 5'd10, 1, 64'd0, 0);
        run_op(2'd2, 64'd77, 64'd0, 5'd11, 1, 64'd0, 0);
        // extra start pulses mid-CALC and in FINISH must be dropped
        run_op(2'd1, 64'd1000, 64'd9, 5'd12, 1, 64'd111, 1);

        // abandon a MUL with reset after edge N+30
        @(negedge clock);
        bus.start         = 1'b1;
        bus.op            = 2'd0;
        bus.operand_a     = 64'd11;
        bus.operand_b     = 64'd13;
        bus.dest_register = 5'd14;
        exp_start         = cyc + 1;
        exp_done          = exp_start + 65;
        exp_res           = 64'd143;
        exp_rd            = 5'd14;
        @(negedge clock);
        bus.start = 1'b0;
        while (cyc < exp_start + 30) @(negedge clock);
        @(posedge clock);
        #3;
        reset     = 1'b1;
        exp_start = 1;
        exp_done  = 0;
        held      = '0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_reg_write", 64'(bus.reg_write), 64'd0);
        chk("arst_result", bus.result, 64'd0);
        chk("arst_rd", 64'(bus.result_register), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_op(2'd0, 64'd3, 64'd5, 5'd15, 1, 64'd15, 0);

        // random mix of opcodes and operand shapes
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [63:0] a;
            logic [63:0] b;
            o = 2'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = 64'd0;
                1: b = 64'($urandom_range(1, 300));
                2: begin a = 64'($urandom_range(0, 5000)); b = -64'($urandom_range(1, 50)); end
                3: b = b >> $urandom_range(1, 63);
                default: ;
            endcase
            run_op(o, a, b, 5'($urandom), 0, 64'd0, ($urandom_range(0, 3) == 0) && (o == 2'd0));
        end

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
